// File: rtl/sdram_wr_burst_feeder.sv
// Drains the SDRAM write-path FIFO (non-showahead read port) into bursts for the
// SDRAM controller write port, tracking a wrapping write address in the region.
module sdram_wr_burst_feeder #(
  parameter int              WIDTH     = 16,
  parameter int              ADDR      = 10,
  parameter int              BURST_LEN = 8,
  parameter int              AW        = 24,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter logic [AW-1:0]   END_ADDR  = 24'h0FFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fifo_rdreq,
  input  logic [WIDTH-1:0] fifo_q,
  input  logic             fifo_rdempty,
  input  logic [ADDR-1:0]  fifo_rdusedw,
  input  logic             flush,
  input  logic             frame_start,
  output logic             wr_req,
  input  logic             wr_ack,
  output logic [AW-1:0]    wr_addr,
  output logic [ADDR:0]    wr_len,
  input  logic             wr_data_req,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic [15:0]      burst_cnt,
  output logic             err_underrun
);
  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  localparam logic [ADDR:0] BL = (ADDR+1)'(BURST_LEN);

  state_t          state_q, state_d;
  logic            wr_req_q, wr_req_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR:0]   wr_len_q, wr_len_d;
  logic [ADDR:0]   cnt_q, cnt_d;
  logic [15:0]     burst_cnt_q, burst_cnt_d;
  logic            err_q, err_d;
  logic            restart_q, restart_d;

  logic [ADDR:0]   lvl;
  logic [AW:0]     len_ext, next_end;
  logic            take;

  // A zero level with the FIFO non-empty means the FIFO is completely full.
  assign lvl      = {!fifo_rdempty && fifo_rdusedw == '0, fifo_rdusedw};
  assign take     = state_q == DATA && wr_data_req && cnt_q < wr_len_q;
  assign len_ext  = (AW+1)'(wr_len_q);
  // Last word the next burst would touch if it reused this burst's length.
  assign next_end = {1'b0, wr_addr_q} + len_ext + len_ext - (AW+1)'(1);

  assign fifo_rdreq   = take && !fifo_rdempty;
  assign wr_data      = fifo_q;
  assign wr_req       = wr_req_q;
  assign wr_addr      = wr_addr_q;
  assign wr_len       = wr_len_q;
  assign busy         = state_q != IDLE;
  assign burst_cnt    = burst_cnt_q;
  assign err_underrun = err_q;

  always_comb begin
    state_d     = state_q;
    wr_req_d    = wr_req_q;
    wr_addr_d   = wr_addr_q;
    wr_len_d    = wr_len_q;
    cnt_d       = cnt_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q;
    restart_d   = restart_q | frame_start;
    case (state_q)
      IDLE: begin
        // A restart (pending or arriving now) beats a launch; the launch retries next cycle.
        if (restart_q || frame_start) begin
          wr_addr_d = BASE_ADDR;
          restart_d = 1'b0;
        end else if (lvl >= BL) begin
          wr_len_d = BL;
          wr_req_d = 1'b1;
          state_d  = REQ;
        end else if (flush && lvl != '0) begin
          wr_len_d = lvl;
          wr_req_d = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (take) begin
          cnt_d = cnt_q + (ADDR+1)'(1);
          if (fifo_rdempty) err_d = 1'b1;
          if (cnt_d == wr_len_q) state_d = DONE;
        end
      end
      default: begin
        burst_cnt_d = burst_cnt_q + 16'd1;
        if (next_end > {1'b0, END_ADDR}) wr_addr_d = BASE_ADDR;
        else                             wr_addr_d = wr_addr_q + AW'(wr_len_q);
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= BASE_ADDR;
      wr_len_q    <= '0;
      cnt_q       <= '0;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_req_q    <= wr_req_d;
      wr_addr_q   <= wr_addr_d;
      wr_len_q    <= wr_len_d;
      cnt_q       <= cnt_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
      restart_q   <= restart_d;
    end
  end
endmodule

// File: tb/tb_sdram_wr_burst_feeder.sv
// Bench for sdram_wr_burst_feeder: behavioural FIFO, controller tasks and a
// queue/arithmetic reference model for addresses, lengths, data and counters.
module tb_sdram_wr_burst_feeder;
  localparam int            WIDTH = 16;
  localparam int            ADDR  = 3;
  localparam int            BL    = 8;
  localparam int            AW    = 24;
  localparam logic [AW-1:0] END_A = 24'h00000F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             fifo_rdreq, fifo_rdempty;
  logic [WIDTH-1:0] fifo_q, wr_data;
  logic [ADDR-1:0]  fifo_rdusedw;
  logic             flush = 1'b0, frame_start = 1'b0, wr_ack = 1'b0, wr_data_req = 1'b0;
  logic             wr_req, busy, err_underrun;
  logic [AW-1:0]    wr_addr;
  logic [ADDR:0]    wr_len;
  logic [15:0]      burst_cnt;

  sdram_wr_burst_feeder #(.WIDTH(WIDTH), .ADDR(ADDR), .BURST_LEN(BL), .AW(AW),
                          .BASE_ADDR(24'h0), .END_ADDR(END_A)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
    .fifo_rdempty(fifo_rdempty), .fifo_rdusedw(fifo_rdusedw), .flush(flush),
    .frame_start(frame_start), .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr),
    .wr_len(wr_len), .wr_data_req(wr_data_req), .wr_data(wr_data), .busy(busy),
    .burst_cnt(burst_cnt), .err_underrun(err_underrun));

  // Behavioural depth-8 FIFO with non-showahead read.
  logic [WIDTH-1:0] mem [0:63];
  int               rp = 0, wp = 0, fcnt;
  logic             push_en = 1'b0, fifo_clr = 1'b0, force_full = 1'b0;
  logic [WIDTH-1:0] push_data = '0, q_r = '0;
  assign fcnt         = wp - rp;
  assign fifo_q       = q_r;
  assign fifo_rdempty = (fcnt == 0);
  assign fifo_rdusedw = force_full ? '0 : fcnt[ADDR-1:0];

  always @(posedge clk) begin
    if (fifo_clr) rp <= wp;
    else if (fifo_rdreq) begin
      q_r <= mem[rp % 64];
      rp  <= rp + 1;
    end
    if (push_en) begin
      mem[wp % 64] <= push_data;
      wp <= wp + 1;
    end
  end

  // Reference model
  logic [WIDTH-1:0] sb[$];
  int  maddr = 0, mbursts = 0, mcount = 0;
  bit  pend = 1'b0;
  int  total = 0, bad = 0;

  task automatic writer(input int n, input bit ramp, input int base);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      logic [WIDTH-1:0] w;
      while (fcnt >= BL && g < 500) begin @(negedge clk); g++; end
      if (fcnt >= BL) begin
        total++; bad++;
        $display("FAIL writer_timeout: fifo level=%0d never dropped below %0d", fcnt, BL);
        return;
      end
      w = ramp ? WIDTH'(base + i) : WIDTH'($urandom);
      push_en = 1'b1; push_data = w; sb.push_back(w);
      @(negedge clk);
      push_en = 1'b0;
    end
  endtask

  task automatic serve_burst(input int len, input int nvalid, input bit fs);
    int t = 0, rd = 0;
    logic [WIDTH-1:0] exp;
    while (wr_req !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    total++;
    if (wr_req !== 1'b1) begin
      bad++; $display("FAIL req_timeout: wr_req=%b want 1", wr_req); return;
    end
    total++;
    if (wr_addr !== AW'(maddr)) begin bad++; $display("FAIL wr_addr: got %h want %h", wr_addr, AW'(maddr)); end
    total++;
    if (wr_len !== (ADDR+1)'(len)) begin bad++; $display("FAIL wr_len: got %0d want %0d", wr_len, len); end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    total++;
    if (wr_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL req_hold: wr_req=%b busy=%b want 1 1", wr_req, busy); end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    force_full = 1'b0;
    total++;
    if (wr_req !== 1'b0) begin bad++; $display("FAIL req_fall: wr_req=%b want 0", wr_req); end
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      wr_data_req = 1'b1;
      if (fs && i == 0) frame_start = 1'b1;
      #1;
      if (fifo_rdreq === 1'b1) rd++;
      @(negedge clk);
      wr_data_req = 1'b0;
      frame_start = 1'b0;
      if (i < nvalid) begin
        exp = sb.pop_front();
        total++;
        if (wr_data !== exp) begin bad++; $display("FAIL wr_data[%0d]: got %h want %h", i, wr_data, exp); end
      end
    end
    total++;
    if (rd != nvalid) begin bad++; $display("FAIL rdreq_count: got %0d want %0d", rd, nvalid); end
    @(negedge clk);
    mbursts++;
    if (maddr + 2 * len - 1 > int'(END_A)) maddr = 0;
    else maddr = maddr + len;
    if (fs) begin pend = 1'b1; end
    if (pend) begin maddr = 0; pend = 1'b0; end
    total++;
    if (burst_cnt !== 16'(mbursts) || busy !== 1'b0) begin
      bad++; $display("FAIL burst_done: burst_cnt=%0d busy=%b want %0d 0", burst_cnt, busy, mbursts);
    end
  endtask

  task automatic check_idle(input string nm);
    repeat (10) @(negedge clk);
    total++;
    if (wr_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s: wr_req=%b busy=%b want 0 0", nm, wr_req, busy);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    total++;
    if (wr_req !== 1'b0 || fifo_rdreq !== 1'b0 || wr_addr !== '0 || wr_len !== '0 ||
        busy !== 1'b0 || burst_cnt !== 16'd0 || err_underrun !== 1'b0) begin
      bad++;
      $display("FAIL %s: req=%b rdreq=%b addr=%h len=%0d busy=%b cnt=%0d err=%b want all zero",
               nm, wr_req, fifo_rdreq, wr_addr, wr_len, busy, burst_cnt, err_underrun);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp;
    fork
      writer(16, 1'b1, 0);
      begin serve_burst(BL, BL, 1'b0); serve_burst(BL, BL, 1'b0); end
    join
    total++;
    if (burst_cnt !== 16'd2 || err_underrun !== 1'b0) begin
      bad++; $display("FAIL ramp_summary: burst_cnt=%0d err=%b want 2 0", burst_cnt, err_underrun);
    end
  endtask

  task automatic test_frame_start;
    fork
      writer(16, 1'b0, 0);
      begin serve_burst(BL, BL, 1'b1); serve_burst(BL, BL, 1'b0); end
    join
  endtask

  task automatic test_wrap;
    fork writer(BL, 1'b0, 0); serve_burst(BL, BL, 1'b0); join
  endtask

  task automatic test_flush;
    writer(5, 1'b0, 0);
    check_idle("no_launch_without_flush");
    flush = 1'b1;
    serve_burst(5, 5, 1'b0);
    flush = 1'b0;
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      int n = $urandom_range(1, 20);
      int tot = mcount + n;
      int k = tot / BL;
      int r = tot % BL;
      fork
        writer(n, 1'b0, 0);
        for (int b = 0; b < k; b++) serve_burst(BL, BL, $urandom_range(0, 3) == 0);
      join
      mcount = r;
      if (r > 0) begin
        check_idle("random_partial_hold");
        if ($urandom_range(0, 1) == 1) begin
          flush = 1'b1;
          serve_burst(r, r, 1'b0);
          flush = 1'b0;
          mcount = 0;
        end
      end
    end
    if (mcount > 0) begin
      flush = 1'b1;
      serve_burst(mcount, mcount, 1'b0);
      flush = 1'b0;
      mcount = 0;
    end
    total++;
    if (err_underrun !== 1'b0) begin bad++; $display("FAIL random_no_underrun: err=%b want 0", err_underrun); end
  endtask

  task automatic test_underrun;
    writer(6, 1'b0, 0);
    force_full = 1'b1;
    serve_burst(BL, 6, 1'b0);
    total++;
    if (err_underrun !== 1'b1) begin bad++; $display("FAIL underrun_set: err=%b want 1", err_underrun); end
    check_idle("underrun_back_to_idle");
    total++;
    if (err_underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky: err=%b want 1", err_underrun); end
  endtask

  task automatic test_reset_mid_data;
    int t = 0;
    writer(BL, 1'b0, 0);
    while (wr_req !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    wr_data_req = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_data_busy: busy=%b want 1", busy); end
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_data");
    wr_data_req = 1'b0;
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
    sb.delete();
    maddr = 0; mbursts = 0; pend = 1'b0; mcount = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset_idle");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_frame_start();
    test_wrap();
    test_flush();
    test_random();
    test_underrun();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_wr_burst_feeder.md
# sdram_wr_burst_feeder

Single-clock drain engine on the read side of the SDRAM write-path async FIFO. It watches the FIFO's read-domain fill level and pulls words with a non-showahead read port: data is valid one cycle after an accepted read. It packages them into bursts for the SDRAM controller's write port and manages a wrapping SDRAM write address. It runs entirely in the FIFO read clock domain.

## Interface
- `WIDTH`, 16, data width (matches FIFO).
- `ADDR`, 10, FIFO level width; FIFO depth = 2^ADDR.
- `BURST_LEN`, 8, words per full burst; must satisfy 1 ≤ BURST_LEN ≤ 2^ADDR.
- `AW`, 24, SDRAM word-address width.
- `BASE_ADDR`, 0, first write address of the buffer region.
- `END_ADDR`, 24'h0FFFFF, last valid word address of the region (inclusive).

Ports:
- `clk`, in, 1, FIFO read clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `fifo_rdreq`, out, 1, FIFO read strobe.
- `fifo_q`, in, WIDTH, FIFO read data, valid the cycle after an accepted read.
- `fifo_rdempty`, in, 1, FIFO empty.
- `fifo_rdusedw`, in, ADDR, FIFO fill level in the read domain.
- `flush`, in, 1, level: allow a partial burst when fewer than BURST_LEN words remain.
- `frame_start`, in, 1, pulse: restart the address at BASE_ADDR before the next burst.
- `wr_req`, out, 1, burst request to the SDRAM controller.
- `wr_ack`, in, 1, one-cycle grant from the controller.
- `wr_addr`, out, AW, burst start address; stable from the rise of `wr_req` to the end of DATA.
- `wr_len`, out, ADDR+1, words in this burst (1..BURST_LEN).
- `wr_data_req`, in, 1, controller pull strobe, one word per cycle.
- `wr_data`, out, WIDTH, equal to `fifo_q`; valid the cycle after `wr_data_req`.
- `busy`, out, 1, high whenever the state is not IDLE.
- `burst_cnt`, out, 16, count of completed bursts; wraps modulo 2^16.
- `err_underrun`, out, 1, sticky: a pull arrived while the FIFO was empty.

## Operation
- Reset (async, `rst_n` = 0): state IDLE.
- Reset values: `wr_req` = 0, `fifo_rdreq` = 0, `wr_addr` = BASE_ADDR, `wr_len` = 0, `busy` = 0, `burst_cnt` = 0, `err_underrun` = 0, word counter = 0, pending-restart flag = 0.
- Effective level `lvl`, ADDR+1 bits, is `{!fifo_rdempty && fifo_rdusedw == 0, fifo_rdusedw}`.
  - When `fifo_rdusedw` = 0 and `fifo_rdempty` = 0, the FIFO is full and `lvl` = 2^ADDR.
- `frame_start` sets the pending-restart flag in any state. The flag is consumed only in IDLE.

State machine:
- IDLE:
  - If the pending-restart flag is set: load `wr_addr` = BASE_ADDR and clear the flag that cycle; no launch that cycle.
  - Else if `lvl` ≥ BURST_LEN: latch `wr_len` = BURST_LEN and go to REQ.
  - Else if `flush` and `lvl` > 0: latch `wr_len` = `lvl` and go to REQ.
- REQ: `wr_req` = 1, registered. Hold until `wr_ack` = 1, then go to DATA with the word counter = 0.
- DATA:
  - `fifo_rdreq` = `wr_data_req` && `!fifo_rdempty` && (counter < `wr_len`). This is combinational.
  - Each `wr_data_req` cycle with counter < `wr_len` increments the counter.
  - If `fifo_rdempty` = 1 in such a cycle, set `err_underrun`; the counter still advances.
  - When the counter reaches `wr_len`, go to DONE. Further `wr_data_req` cycles are ignored.
- DONE, one cycle:
  - `burst_cnt` += 1.
  - If `wr_addr + wr_len + wr_len - 1` > END_ADDR (the next burst would cross END_ADDR), set `wr_addr` = BASE_ADDR.
  - Otherwise set `wr_addr` += `wr_len`.
  - Return to IDLE.
- Address arithmetic is done at AW+1 bits to detect overflow. Bursts never straddle END_ADDR, provided the region size is a multiple of BURST_LEN.
- Simultaneous events:
  - `frame_start` together with a launch condition in IDLE: restart wins and the launch is deferred one cycle.
  - `wr_ack` arriving in the same cycle `wr_req` rises is legal.
- `flush` is sampled only in IDLE; deasserting it mid-burst has no effect.

## Timing
- IDLE→REQ decision is registered: `wr_req` rises one clk after `lvl` ≥ BURST_LEN is seen in IDLE.
- `wr_req` falls the cycle after `wr_ack`.
- `wr_data` (= `fifo_q`) is valid one clk after each `wr_data_req`. The controller must capture with one-cycle latency.
- Minimum full-burst occupancy is 1 (REQ) + BURST_LEN (DATA) + 1 (DONE) cycles, plus the ack wait.
- `fifo_rdusedw` lags writes by 2–3 cycles through the FIFO synchronizers. It only ever under-reports, so a launch never overreads.

## Test plan
- Ramp 0..15 into FIFO, BURST_LEN=8 → two bursts at `wr_addr` 0x000000 then 0x000008, `wr_data` 0..7 then 8..15, `burst_cnt` = 2, `err_underrun` = 0.
- 5 words, `flush` = 0 → no `wr_req`; then `flush` = 1 → one burst, `wr_len` = 5, data intact, `fifo_rdreq` high exactly 5 cycles.
- END_ADDR=0x0F, 24 words → addresses 0x00, 0x08, then 0x00 (wrap); `burst_cnt` = 3.
- FIFO full (`fifo_rdusedw` = 0, `fifo_rdempty` = 0), ADDR=3, BURST_LEN=8 → `lvl` = 8 and a burst launches.
- `frame_start` pulsed during DATA of the burst at 0x08 → DONE advances the address to 0x10, the next IDLE reloads 0x00, and the next burst goes to 0x00.
- Controller issues 8 `wr_data_req` with only 6 words present (forced `fifo_rdusedw`) → `err_underrun` = 1 and sticky, FSM returns to IDLE; `rst_n` pulse mid-DATA → all outputs return to their reset values immediately.
